// File: rtl/brownout_ctrl.sv
// brownout_ctrl: host-side sequencer for the brownout macro (enable, settle masking, event capture).
// Optional feature macro: BROWNOUT_CTRL_VUNDER_IRQ_EN enables the vunder_irq latch.
module brownout_ctrl #(
  parameter int SETTLE_CYCLES = 1024,
  parameter int CNT_W         = 8,
  parameter int SYNC_STAGES   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_ena,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [2:0]       cfg_otrip,
  input  logic [2:0]       cfg_vtrip,
  input  logic [2:0]       cfg_force,
  input  logic             irq_clr,
  input  logic             cnt_clr,
  output logic             ena,
  output logic [2:0]       otrip,
  output logic [2:0]       vtrip,
  output logic             force_ena_rc_osc,
  output logic             force_dis_rc_osc,
  output logic             force_short_oneshot,
  input  logic             bod_out,
  input  logic             bod_vunder,
  input  logic             bod_timed_out,
  output logic             bod_irq,
  output logic             vunder_irq,
  output logic [4:0]       status,
  output logic [CNT_W-1:0] event_cnt
);

  typedef enum logic [1:0] {
    OFF     = 2'd0,
    SETTLE  = 2'd1,
    ARMED   = 2'd2,
    TRIPPED = 2'd3
  } state_t;

  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);

  state_t                 state;
  logic [SET_W-1:0]       settle_cnt;
  logic [SYNC_STAGES-1:0] out_sync;
  logic [SYNC_STAGES-1:0] vunder_sync;
  logic [SYNC_STAGES-1:0] timed_sync;
  logic                   out_s;
  logic                   vunder_s;
  logic                   timed_out_s;
  logic                   out_prev;
  logic                   out_rise;
  logic                   bod_event;
  logic                   cfg_write;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign out_s       = out_sync[SYNC_STAGES-1];
  assign vunder_s    = vunder_sync[SYNC_STAGES-1];
  assign timed_out_s = timed_sync[SYNC_STAGES-1];
  assign out_rise    = out_s & ~out_prev;
  assign bod_event   = (state == ARMED) & out_rise;
  assign cfg_write   = cfg_valid & cfg_ready;
  assign status      = {timed_out_s, vunder_s, out_s, state};

  // Input synchronizers and the brownout edge-detect flop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_sync    <= '0;
      vunder_sync <= '0;
      timed_sync  <= '0;
      out_prev    <= 1'b0;
    end else begin
      out_sync    <= {out_sync[SYNC_STAGES-2:0], bod_out};
      vunder_sync <= {vunder_sync[SYNC_STAGES-2:0], bod_vunder};
      timed_sync  <= {timed_sync[SYNC_STAGES-2:0], bod_timed_out};
      out_prev    <= out_s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      otrip               <= '0;
      vtrip               <= '0;
      force_short_oneshot <= 1'b0;
      force_dis_rc_osc    <= 1'b0;
      force_ena_rc_osc    <= 1'b0;
    end else if (cfg_write) begin
      otrip               <= cfg_otrip;
      vtrip               <= cfg_vtrip;
      force_short_oneshot <= cfg_force[2];
      force_dis_rc_osc    <= cfg_force[1];
      force_ena_rc_osc    <= cfg_force[0];
    end
  end

  // Dropping cfg_ena overrides everything; a write while armed restarts settling
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= OFF;
      settle_cnt <= '0;
      ena        <= 1'b0;
      cfg_ready  <= 1'b1;
    end else if (!cfg_ena) begin
      state      <= OFF;
      settle_cnt <= '0;
      ena        <= 1'b0;
      cfg_ready  <= 1'b1;
    end else begin
      case (state)
        OFF: begin
          state      <= SETTLE;
          settle_cnt <= '0;
          ena        <= 1'b1;
          cfg_ready  <= 1'b0;
        end
        SETTLE: begin
          if (settle_cnt == SET_LAST) begin
            state      <= ARMED;
            settle_cnt <= '0;
            cfg_ready  <= 1'b1;
          end else begin
            settle_cnt <= settle_cnt + SET_W'(1);
          end
        end
        ARMED: begin
          if (cfg_write) begin
            state      <= SETTLE;
            settle_cnt <= '0;
            cfg_ready  <= 1'b0;
          end else if (out_rise) begin
            state <= TRIPPED;
          end
        end
        TRIPPED: begin
          if (cfg_write) begin
            state      <= SETTLE;
            settle_cnt <= '0;
            cfg_ready  <= 1'b0;
          end else if (!out_s) begin
            state <= ARMED;
          end
        end
      endcase
    end
  end

  // A set beats a same-cycle clear; a count beats a same-cycle counter clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bod_irq   <= 1'b0;
      event_cnt <= '0;
    end else begin
      if (bod_event)    bod_irq <= 1'b1;
      else if (irq_clr) bod_irq <= 1'b0;

      if (bod_event)    event_cnt <= cnt_clr ? CNT_W'(1) : sat_inc(event_cnt);
      else if (cnt_clr) event_cnt <= '0;
    end
  end

`ifdef BROWNOUT_CTRL_VUNDER_IRQ_EN
  logic vunder_prev;
  logic vunder_rise;

  assign vunder_rise = vunder_s & ~vunder_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vunder_prev <= 1'b0;
      vunder_irq  <= 1'b0;
    end else begin
      vunder_prev <= vunder_s;
      if (vunder_rise && (state == ARMED || state == TRIPPED)) vunder_irq <= 1'b1;
      else if (irq_clr)                                         vunder_irq <= 1'b0;
    end
  end
`else
  assign vunder_irq = 1'b0;
`endif

endmodule

// File: tb/tb_brownout_ctrl.sv
// Directed/randomized bench for brownout_ctrl with SETTLE_CYCLES=16, CNT_W=2.
module tb_brownout_ctrl;

  localparam int SETTLE = 16;
  localparam int CW     = 2;
  localparam int CMAX   = (1 << CW) - 1;
`ifdef BROWNOUT_CTRL_VUNDER_IRQ_EN
  localparam logic VIRQ = 1'b1;
`else
  localparam logic VIRQ = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_ena;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [2:0]    cfg_otrip;
  logic [2:0]    cfg_vtrip;
  logic [2:0]    cfg_force;
  logic          irq_clr;
  logic          cnt_clr;
  logic          ena;
  logic [2:0]    otrip;
  logic [2:0]    vtrip;
  logic          force_ena_rc_osc;
  logic          force_dis_rc_osc;
  logic          force_short_oneshot;
  logic          bod_out;
  logic          bod_vunder;
  logic          bod_timed_out;
  logic          bod_irq;
  logic          vunder_irq;
  logic [4:0]    status;
  logic [CW-1:0] event_cnt;

  int checks = 0;
  int errors = 0;
  int events = 0;

  brownout_ctrl #(.SETTLE_CYCLES(SETTLE), .CNT_W(CW), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .cfg_ena(cfg_ena), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_otrip(cfg_otrip), .cfg_vtrip(cfg_vtrip), .cfg_force(cfg_force),
    .irq_clr(irq_clr), .cnt_clr(cnt_clr), .ena(ena), .otrip(otrip), .vtrip(vtrip),
    .force_ena_rc_osc(force_ena_rc_osc), .force_dis_rc_osc(force_dis_rc_osc),
    .force_short_oneshot(force_short_oneshot), .bod_out(bod_out), .bod_vunder(bod_vunder),
    .bod_timed_out(bod_timed_out), .bod_irq(bod_irq), .vunder_irq(vunder_irq),
    .status(status), .event_cnt(event_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic int sat(input int n);
    return (n > CMAX) ? CMAX : n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Caller has already raised cfg_ena or cfg_valid; state must read SETTLE for SETTLE cycles
  task automatic run_settle(input string tag);
    step(1);
    cfg_valid = 1'b0;
    chk({tag, "_ena"}, 32'(ena), 1);
    for (int i = 0; i < SETTLE; i++) begin
      chk({tag, "_settle_state"}, 32'(status[1:0]), 1);
      chk({tag, "_settle_ready"}, 32'(cfg_ready), 0);
      step(1);
    end
    chk({tag, "_armed_state"}, 32'(status[1:0]), 2);
    chk({tag, "_armed_ready"}, 32'(cfg_ready), 1);
  endtask

  // One brownout pulse while ARMED: width >= 3 cycles, gap lets the FSM return to ARMED
  task automatic pulse(input string tag, input int width, input int gap);
    bod_out = 1'b1;
    step(2);
    chk({tag, "_out_s"}, 32'(status[2]), 1);
    chk({tag, "_cnt_early"}, 32'(event_cnt), sat(events));
    step(1);
    events++;
    chk({tag, "_cnt"}, 32'(event_cnt), sat(events));
    chk({tag, "_irq"}, 32'(bod_irq), 1);
    chk({tag, "_tripped"}, 32'(status[1:0]), 3);
    step(width - 3);
    bod_out = 1'b0;
    step(2);
    chk({tag, "_still_tripped"}, 32'(status[1:0]), 3);
    step(1);
    chk({tag, "_rearmed"}, 32'(status[1:0]), 2);
    step(gap);
  endtask

  initial begin
    int n;
    logic [2:0] o, v, f;

    rst = 1'b1; cfg_ena = 1'b0; cfg_valid = 1'b0; cfg_otrip = '0; cfg_vtrip = '0;
    cfg_force = '0; irq_clr = 1'b0; cnt_clr = 1'b0; bod_out = 1'b0; bod_vunder = 1'b0;
    bod_timed_out = 1'b0;
    step(2);
    rst = 1'b0;
    step(1);
    chk("rst_ena", 32'(ena), 0);
    chk("rst_otrip", 32'(otrip), 0);
    chk("rst_vtrip", 32'(vtrip), 0);
    chk("rst_force", 32'({force_short_oneshot, force_dis_rc_osc, force_ena_rc_osc}), 0);
    chk("rst_ready", 32'(cfg_ready), 1);
    chk("rst_irq", 32'({bod_irq, vunder_irq}), 0);
    chk("rst_cnt", 32'(event_cnt), 0);
    chk("rst_status", 32'(status), 0);

    cfg_ena = 1'b1;
    run_settle("en");

    pulse("p0", $urandom_range(12, 3), $urandom_range(8, 4));
    irq_clr = 1'b1;
    step(1);
    irq_clr = 1'b0;
    chk("irq_clr", 32'(bod_irq), 0);
    chk("cnt_after_clr", 32'(event_cnt), sat(events));

    n = 4 + $urandom_range(2, 0);
    for (int p = 0; p < n; p++) pulse("pn", $urandom_range(8, 3), $urandom_range(8, 4));
    chk("cnt_saturated", 32'(event_cnt), CMAX);

    irq_clr = 1'b1;
    step(1);
    irq_clr = 1'b0;
    chk("irq_clr2", 32'(bod_irq), 0);
    // Event lands on the same edge as both clears
    bod_out = 1'b1;
    step(2);
    cnt_clr = 1'b1;
    irq_clr = 1'b1;
    step(1);
    cnt_clr = 1'b0;
    irq_clr = 1'b0;
    events = 1;
    chk("clr_with_event_cnt", 32'(event_cnt), 1);
    chk("clr_with_event_irq", 32'(bod_irq), 1);
    step($urandom_range(5, 1));
    bod_out = 1'b0;
    step(5);
    cnt_clr = 1'b1;
    irq_clr = 1'b1;
    step(1);
    cnt_clr = 1'b0;
    irq_clr = 1'b0;
    events = 0;
    chk("cnt_clr", 32'(event_cnt), 0);

    f = 3'($urandom_range(7, 0));
    cfg_otrip = 3'd5; cfg_vtrip = 3'd2; cfg_force = f; cfg_valid = 1'b1;
    step(1);
    cfg_valid = 1'b0;
    chk("wr_otrip", 32'(otrip), 5);
    chk("wr_vtrip", 32'(vtrip), 2);
    chk("wr_force", 32'({force_short_oneshot, force_dis_rc_osc, force_ena_rc_osc}), 32'(f));
    chk("wr_settle", 32'(status[1:0]), 1);
    for (int i = 1; i < SETTLE; i++) begin
      bod_out = (i <= 5);
      cfg_valid = (i == 3);
      cfg_otrip = 3'd1;
      step(1);
      chk("wr_settle_state", 32'(status[1:0]), 1);
      chk("wr_settle_irq", 32'(bod_irq), 0);
    end
    bod_out = 1'b0;
    cfg_valid = 1'b0;
    step(1);
    chk("wr_rearmed", 32'(status[1:0]), 2);
    chk("wr_masked_cnt", 32'(event_cnt), 0);
    chk("wr_masked_irq", 32'(bod_irq), 0);
    chk("wr_ignored", 32'(otrip), 5);

    cfg_ena = 1'b0;
    step(1);
    chk("off_state", 32'(status[1:0]), 0);
    chk("off_ena", 32'(ena), 0);
    o = 3'($urandom_range(7, 1)); v = 3'($urandom_range(7, 0)); f = 3'($urandom_range(7, 0));
    cfg_otrip = o; cfg_vtrip = v; cfg_force = f; cfg_valid = 1'b1;
    step(1);
    cfg_valid = 1'b0;
    chk("offwr_otrip", 32'(otrip), 32'(o));
    chk("offwr_vtrip", 32'(vtrip), 32'(v));
    chk("offwr_state", 32'(status[1:0]), 0);
    cfg_ena = 1'b1;
    step(1);
    chk("mid_settle", 32'(status[1:0]), 1);
    step(7);
    cfg_ena = 1'b0;
    step(1);
    chk("drop_state", 32'(status[1:0]), 0);
    chk("drop_ena", 32'(ena), 0);
    cfg_ena = 1'b1;
    run_settle("reen");

    bod_vunder = 1'b1;
    step(2);
    chk("vunder_s", 32'(status[3]), 1);
    irq_clr = 1'b1;
    step(1);
    irq_clr = 1'b0;
    chk("vunder_irq_setwins", 32'(vunder_irq), 32'(VIRQ));
    irq_clr = 1'b1;
    step(1);
    irq_clr = 1'b0;
    chk("vunder_irq_clr", 32'(vunder_irq), 0);
    bod_vunder = 1'b0;
    bod_timed_out = 1'b1;
    step(2);
    chk("timed_out_s", 32'(status[4]), 1);
    bod_timed_out = 1'b0;
    step(2);
    chk("timed_out_s_low", 32'(status[4]), 0);

    pulse("pre_rst", $urandom_range(6, 3), 4);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_ena", 32'(ena), 0);
    chk("arst_otrip", 32'(otrip), 0);
    chk("arst_force", 32'({force_short_oneshot, force_dis_rc_osc, force_ena_rc_osc}), 0);
    chk("arst_ready", 32'(cfg_ready), 1);
    chk("arst_irq", 32'(bod_irq), 0);
    chk("arst_cnt", 32'(event_cnt), 0);
    chk("arst_status", 32'(status), 0);
    step(1);
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
